// File: rtl/cycle_counter_pkg.sv
// Shared types and register map for the cycle counter bank.
package cycle_counter_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  // Per-channel register offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Global register offsets
  localparam logic [1:0] REG_PRESC     = 2'd0;
  localparam logic [1:0] REG_START_ALL = 2'd1;
  localparam logic [1:0] REG_STOP_ALL  = 2'd2;

  localparam logic [3:0] GLOBAL_IDX = 4'hF;

  // Decoded bus request for one channel
  typedef struct packed {
    logic        ctrl_we;
    logic        count_we;
    logic        cmp_we;
    logic        status_we;
    logic        start;
    logic        stop;
    logic        clear;
    logic [31:0] wdata;
  } ch_req_t;

endpackage

// File: rtl/cycle_counter_channel.sv
// One counter channel: run/stop FSM, count, compare value and sticky flags.
module cycle_counter_channel
  import cycle_counter_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  ch_req_t          req,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] cmp,
  output logic [2:0]       status,
  output logic             irq_req
);

  state_e           state;
  logic [CNT_W-1:0] count_nxt;
  logic             match_ie, ovf, match;
  logic             load, inc, at_max, ovf_set, match_set;

  assign at_max = (count == '1);

  always_comb begin
    count_nxt = count;
    load      = 1'b0;
    inc       = 1'b0;
    if (req.clear) begin
      count_nxt = '0;
      load      = 1'b1;
    end else if (req.count_we) begin
      count_nxt = req.wdata[CNT_W-1:0];
      load      = 1'b1;
    end else if (state == ST_RUNNING && tick) begin
      inc = 1'b1;
      if (!at_max)        count_nxt = count + CNT_W'(1);
      else if (!SATURATE) count_nxt = '0;
    end
  end

  // A saturated hold is not an update, so it cannot raise match
  assign ovf_set   = inc && at_max;
  assign match_set = (load || (inc && count_nxt != count)) && (count_nxt == cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_STOPPED;
      count    <= '0;
      cmp      <= '0;
      match_ie <= 1'b0;
      ovf      <= 1'b0;
      match    <= 1'b0;
    end else begin
      count <= count_nxt;
      if (req.stop)       state <= ST_STOPPED;
      else if (req.start) state <= ST_RUNNING;
      if (req.cmp_we)  cmp      <= req.wdata[CNT_W-1:0];
      if (req.ctrl_we) match_ie <= req.wdata[2];
      ovf   <= ovf_set   || (ovf   && !(req.status_we && req.wdata[1]));
      match <= match_set || (match && !(req.status_we && req.wdata[2]));
    end
  end

  assign status  = {match, ovf, state == ST_RUNNING};
  assign irq_req = match && match_ie;

endmodule

// File: rtl/cycle_counter_bank.sv
// Bank of memory-mapped cycle counters with a shared prescaler and OR-ed irq.
module cycle_counter_bank
  import cycle_counter_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 32,
  parameter int PRESC_W  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]         idx;
  logic [1:0]         rsel;
  logic               glb_sel, start_all_we, stop_all_we, presc_we, tick;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [31:0]        rd_val;
  cmd_e               cmd;

  logic [N_CH-1:0][CNT_W-1:0] ch_count;
  logic [N_CH-1:0][CNT_W-1:0] ch_cmp;
  logic [N_CH-1:0][2:0]       ch_status;
  logic [N_CH-1:0]            ch_irq;

  assign idx          = addr[5:2];
  assign rsel         = addr[1:0];
  assign cmd          = cmd_e'(wdata[1:0]);
  assign glb_sel      = (idx == GLOBAL_IDX);
  assign presc_we     = we && glb_sel && rsel == REG_PRESC;
  assign start_all_we = we && glb_sel && rsel == REG_START_ALL;
  assign stop_all_we  = we && glb_sel && rsel == REG_STOP_ALL;

  // Down-counter: tick while at zero, then reload from presc
  assign tick = (pcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      pcnt  <= '0;
    end else if (presc_we) begin
      presc <= wdata[PRESC_W-1:0];
      pcnt  <= wdata[PRESC_W-1:0];
    end else if (tick) begin
      pcnt <= presc;
    end else begin
      pcnt <= pcnt - PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic    sel;
    ch_req_t req;
    assign sel = we && (idx == 4'(i));
    assign req = '{
      ctrl_we:   sel && rsel == REG_CTRL,
      count_we:  sel && rsel == REG_COUNT,
      cmp_we:    sel && rsel == REG_CMP,
      status_we: sel && rsel == REG_STATUS,
      start:     (sel && rsel == REG_CTRL && cmd == CMD_START) || (start_all_we && wdata[i]),
      stop:      (sel && rsel == REG_CTRL && cmd == CMD_STOP)  || (stop_all_we  && wdata[i]),
      clear:     sel && rsel == REG_CTRL && cmd == CMD_CLEAR,
      wdata:     wdata
    };

    cycle_counter_channel #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .req     (req),
      .count   (ch_count[i]),
      .cmp     (ch_cmp[i]),
      .status  (ch_status[i]),
      .irq_req (ch_irq[i])
    );
  end

  // CTRL and unmapped locations read as zero
  always_comb begin
    rd_val = '0;
    if (glb_sel) begin
      if (rsel == REG_PRESC) rd_val = 32'(presc);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (idx == 4'(i)) begin
          case (rsel)
            REG_COUNT:  rd_val = 32'(ch_count[i]);
            REG_CMP:    rd_val = 32'(ch_cmp[i]);
            REG_STATUS: rd_val = 32'(ch_status[i]);
            default:    rd_val = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (re) rdata <= rd_val;
      irq <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_cycle_counter_bank.sv
// Directed bench: register table plus hand-timed run/stop, wrap, irq and reset sequences.
module tb_cycle_counter_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata, rdata_w, rdata_s;
  logic        irq, irq_w, irq_s;
  int          n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  cycle_counter_bank #(.N_CH(4), .CNT_W(32), .PRESC_W(8), .SATURATE(1'b0)) u_dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq));

  cycle_counter_bank #(.N_CH(4), .CNT_W(8), .PRESC_W(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata_w), .irq(irq_w));

  cycle_counter_bank #(.N_CH(4), .CNT_W(8), .PRESC_W(8), .SATURATE(1'b1)) u_s8 (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata_s), .irq(irq_s));

  typedef struct {
    logic        we;
    logic        re;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        chk;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] ra(input int ch, input int r);
    return 6'(ch * 4 + r);
  endfunction

  function automatic void add(input logic w, input logic r, input logic [5:0] a,
                              input logic [31:0] d, input logic [31:0] e,
                              input logic c, input string n);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.exp = e; v.chk = c; v.name = n;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on negedge, edge takes effect, outputs sampled 1ns later
  task automatic cyc(input logic r, input logic w, input logic rd_en,
                     input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = r; we = w; re = rd_en; addr = a; wdata = d;
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [5:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic nop(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 6'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 6'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Register access table, applied right after reset
    add(0, 1, ra(0, 1),  32'h0,        32'h0,        1, "rst_count0");
    add(0, 1, ra(3, 3),  32'h0,        32'h0,        1, "rst_status3");
    add(0, 1, ra(15, 0), 32'h0,        32'h0,        1, "rst_presc");
    add(1, 0, ra(2, 2),  32'hDEADBEEF, 32'h0,        0, "");
    add(0, 1, ra(2, 2),  32'h0,        32'hDEADBEEF, 1, "cmp_rw");
    add(0, 0, ra(0, 0),  32'h0,        32'hDEADBEEF, 1, "rdata_hold");
    add(1, 0, ra(3, 1),  32'h12345678, 32'h0,        0, "");
    add(0, 1, ra(3, 1),  32'h0,        32'h12345678, 1, "count_preload");
    add(0, 1, ra(3, 3),  32'h0,        32'h0,        1, "status_no_match");
    add(1, 0, ra(3, 2),  32'h55,       32'h0,        0, "");
    add(1, 0, ra(3, 1),  32'h55,       32'h0,        0, "");
    add(0, 1, ra(3, 3),  32'h0,        32'h4,        1, "preload_match");
    add(1, 0, ra(3, 3),  32'h4,        32'h0,        0, "");
    add(0, 1, ra(3, 3),  32'h0,        32'h0,        1, "w1c_match");
    add(1, 0, ra(5, 1),  32'h7,        32'h0,        0, "");
    add(0, 1, ra(5, 1),  32'h0,        32'h0,        1, "unmapped_ch");
    add(0, 1, ra(15, 3), 32'h0,        32'h0,        1, "unmapped_glb");
    add(1, 0, ra(15, 0), 32'h1FF,      32'h0,        0, "");
    add(0, 1, ra(15, 0), 32'h0,        32'hFF,       1, "presc_trunc");
    add(1, 0, ra(15, 0), 32'h0,        32'h0,        0, "");
    add(1, 1, ra(3, 1),  32'h99,       32'h55,       1, "we_re_count");
    add(0, 1, ra(3, 1),  32'h0,        32'h99,       1, "count_after");

    do_reset();
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_8bit", 32'({irq_w, irq_s}), 32'h0);

    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk) check(tbl[i].name, rdata, tbl[i].exp);
    end

    // Start/stop at PRESC=0: 10 running edges give 10 counts
    do_reset();
    wr(ra(15, 0), 32'h0);
    wr(ra(0, 0), 32'h1);
    nop(9);
    wr(ra(0, 0), 32'h2);
    rd(ra(0, 1));
    check("t1_count", rdata, 32'd10);
    nop(5);
    rd(ra(0, 1));
    check("t1_count_held", rdata, 32'd10);
    rd(ra(0, 3));
    check("t1_status", rdata, 32'h0);

    // PRESC=3: 40 running cycles give 10 ticks
    do_reset();
    wr(ra(15, 0), 32'h3);
    wr(ra(1, 0), 32'h1);
    nop(20);
    rd(ra(1, 3));
    check("t2_status_running", rdata, 32'h1);
    rd(ra(0, 1));
    check("t2_ch0_idle", rdata, 32'h0);
    nop(17);
    wr(ra(1, 0), 32'h2);
    rd(ra(1, 1));
    check("t2_count", rdata, 32'd10);

    // 8-bit wrap vs saturate, 3 ticks from 0xFE
    do_reset();
    wr(ra(0, 1), 32'hFE);
    wr(ra(0, 0), 32'h1);
    nop(2);
    wr(ra(0, 0), 32'h2);
    rd(ra(0, 1));
    check("t3_wrap_count", rdata_w, 32'h01);
    check("t3_sat_count", rdata_s, 32'hFF);
    check("t3_wide_count", rdata, 32'h101);
    rd(ra(0, 3));
    check("t3_wrap_status", rdata_w, 32'h6);
    check("t3_sat_status", rdata_s, 32'h2);
    check("t3_wide_status", rdata, 32'h0);
    wr(ra(0, 3), 32'h2);
    rd(ra(0, 3));
    check("t3_wrap_w1c_ovf", rdata_w, 32'h4);
    check("t3_sat_w1c_ovf", rdata_s, 32'h0);
    wr(ra(0, 1), 32'h1234);
    rd(ra(0, 1));
    check("t3_trunc_8bit", rdata_w, 32'h34);
    check("t3_wide_preload", rdata, 32'h1234);

    // Compare match and irq timing
    do_reset();
    wr(ra(0, 2), 32'h5);
    wr(ra(0, 0), 32'h5);
    nop(5);
    check("t4_irq_pre", 32'(irq), 32'h0);
    rd(ra(0, 1));
    check("t4_count5", rdata, 32'h5);
    check("t4_irq_set", 32'(irq), 32'h1);
    wr(ra(0, 3), 32'h4);
    nop(1);
    check("t4_irq_cleared", 32'(irq), 32'h0);
    rd(ra(0, 1));
    check("t4_count_continues", rdata, 32'h8);
    rd(ra(0, 3));
    check("t4_status_after_w1c", rdata, 32'h1);
    wr(ra(0, 2), 32'd12);
    wr(ra(0, 3), 32'h4);
    rd(ra(0, 3));
    check("t4_set_beats_w1c", rdata, 32'h5);
    check("t4_irq_reset", 32'(irq), 32'h1);

    // Clear beats increment; START_ALL then STOP_ALL
    do_reset();
    wr(ra(0, 0), 32'h1);
    nop(2);
    wr(ra(0, 0), 32'h3);
    rd(ra(0, 1));
    check("t5_clear_count", rdata, 32'h0);
    rd(ra(0, 3));
    check("t5_clear_keeps_run", rdata, 32'h5);
    wr(ra(15, 1), 32'hF);
    wr(ra(15, 2), 32'h1);
    for (int i = 0; i < 4; i++) begin
      rd(ra(i, 3));
      check($sformatf("t5_status_ch%0d", i), rdata, (i == 0) ? 32'h4 : 32'h1);
    end

    // Reset mid-run with pending command and read
    do_reset();
    wr(ra(0, 1), 32'h1230);
    wr(ra(0, 2), 32'h1234);
    wr(ra(0, 0), 32'h5);
    nop(3);
    rd(ra(0, 1));
    check("t6_pre_count", rdata, 32'h1233);
    cyc(1'b1, 1'b1, 1'b1, ra(0, 0), 32'h1);
    check("t6_rdata", rdata, 32'h0);
    check("t6_irq", 32'(irq), 32'h0);
    rd(ra(0, 1));
    check("t6_count", rdata, 32'h0);
    rd(ra(0, 3));
    check("t6_status", rdata, 32'h0);
    rd(ra(0, 1));
    check("t6_still_stopped", rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
